mips_multicycle_processor: RTL and testbench

MIPS_MULTICYCLE_PROCESSOR -- requirements
Module: mips_multicycle_processor

---
 rtl/mips_pkg.sv | 57 +++++
 rtl/mips_mc_control.sv | 109 ++++++++++
 rtl/mips_multicycle_processor.sv | 140 ++++++++++++++
 tb/tb_mips_multicycle_processor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, types and ALU helper for the multicycle MIPS core
package mips_pkg;

  localparam logic [31:0] TEXT_BASE     = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE     = 32'h1001_0000;
  localparam logic [31:0] PORT_OUT_ADDR = 32'h1001_0024;
  localparam logic [31:0] PORT_IN_ADDR  = 32'h1001_0028;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} stateT;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } aluOpT;

  typedef enum logic [2:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_JUMP, CLS_ILLEGAL
  } instrClassT;

  function automatic logic [31:0] aluCompute(input aluOpT op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] shamt);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_NOR: return ~(a | b);
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: return b << shamt;
      ALU_SRL: return b >> shamt;
      ALU_LUI: return {b[15:0], 16'b0};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multicycle FSM and instruction decode
// InstrDone is registered, so it is raised on the edge that enters each instruction's final state.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] irOpcode,
  input  logic [5:0] irFunct,
  input  logic [5:0] fetchOpcode,
  input  logic [5:0] fetchFunct,
  output stateT      state,
  output instrClassT instrClass,
  output aluOpT      aluOp,
  output logic       instrDone,
  output logic       halted
);

  function automatic instrClassT classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLL, F_SRL: return CLS_ALU_R;
          F_JR:    return CLS_JUMP;
          default: return CLS_ILLEGAL;
        endcase
      end
      OP_J, OP_JAL:                               return CLS_JUMP;
      OP_BEQ, OP_BNE:                             return CLS_BRANCH;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI:  return CLS_ALU_I;
      OP_LW:                                      return CLS_LOAD;
      OP_SW:                                      return CLS_STORE;
      default:                                    return CLS_ILLEGAL;
    endcase
  endfunction

  instrClassT fetchClass;

  assign instrClass = classify(irOpcode, irFunct);
  assign fetchClass = classify(fetchOpcode, fetchFunct);

  always_comb begin
    aluOp = ALU_ADD;
    if (irOpcode == OP_RTYPE) begin
      case (irFunct)
        F_SUB:   aluOp = ALU_SUB;
        F_AND:   aluOp = ALU_AND;
        F_OR:    aluOp = ALU_OR;
        F_NOR:   aluOp = ALU_NOR;
        F_SLT:   aluOp = ALU_SLT;
        F_SLL:   aluOp = ALU_SLL;
        F_SRL:   aluOp = ALU_SRL;
        default: aluOp = ALU_ADD;
      endcase
    end else begin
      case (irOpcode)
        OP_SLTI: aluOp = ALU_SLT;
        OP_ANDI: aluOp = ALU_AND;
        OP_ORI:  aluOp = ALU_OR;
        OP_LUI:  aluOp = ALU_LUI;
        default: aluOp = ALU_ADD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      instrDone <= 1'b0;
      halted    <= 1'b0;
    end else begin
      instrDone <= 1'b0;
      case (state)
        FETCH: begin
          state     <= DECODE;
          instrDone <= (fetchClass == CLS_JUMP);
        end
        DECODE: begin
          case (instrClass)
            CLS_JUMP:    state <= FETCH;
            CLS_ILLEGAL: begin
              state  <= TRAP;
              halted <= 1'b1;
            end
            default:     state <= EXEC;
          endcase
          instrDone <= (instrClass == CLS_BRANCH);
        end
        EXEC: begin
          if (instrClass == CLS_BRANCH)
            state <= FETCH;
          else if (instrClass == CLS_LOAD || instrClass == CLS_STORE)
            state <= MEM;
          else
            state <= WB;
          instrDone <= (instrClass != CLS_LOAD && instrClass != CLS_BRANCH);
        end
        MEM: begin
          state     <= (instrClass == CLS_LOAD) ? WB : FETCH;
          instrDone <= (instrClass == CLS_LOAD);
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_processor.sv
// rtl/mips_multicycle_processor.sv - multicycle MIPS datapath with register file, memories and MMIO ports
module mips_multicycle_processor
  import mips_pkg::*;
#(
  parameter int MEMORY_DEPTH      = 32,
  parameter int DATA_MEMORY_DEPTH = 64,
  parameter int PORT_WIDTH        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PORT_WIDTH-1:0] PortIn,
  output logic [31:0]           ALUResultOut,
  output logic [31:0]           PortOut,
  output logic                  InstrDone,
  output logic                  Halted
);

  localparam int PIDX = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int DIDX = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;

  logic [31:0] progMem [MEMORY_DEPTH];
  logic [31:0] dataMem [DATA_MEMORY_DEPTH];
  logic [31:0] regFile [32];

  logic [31:0] pc, ir, regA, regB, aluOut, mdr, portOutReg;

  stateT      state;
  instrClassT instrClass;
  aluOpT      aluOp;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wbReg;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] immSext, immExt, aluB, aluResult, wbData, fetchedInstr;
  logic [29:0] pcWord, dataWord;
  logic [DIDX-1:0] ramIdx;
  logic        isPortOut, isPortIn, takenBranch;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];
  assign target = ir[25:0];

  // Fetches past the end of program memory return 0, which decodes as sll $0,$0,0.
  assign pcWord       = pc[31:2] - TEXT_BASE[31:2];
  assign fetchedInstr = (pcWord < 30'(MEMORY_DEPTH)) ? progMem[pcWord[PIDX-1:0]] : 32'h0;

  assign immSext   = {{16{imm[15]}}, imm};
  assign immExt    = (opcode == OP_ANDI || opcode == OP_ORI) ? {16'b0, imm} : immSext;
  assign aluB      = (instrClass == CLS_ALU_R) ? regB : immExt;
  assign aluResult = aluCompute(aluOp, regA, aluB, shamt);

  assign takenBranch = (regA == regB) != (opcode == OP_BNE);
  assign wbReg       = (instrClass == CLS_ALU_R) ? rd : rt;
  assign wbData      = (instrClass == CLS_LOAD) ? mdr : aluOut;

  // Address low bits are dropped everywhere; RAM wraps modulo its depth.
  assign dataWord  = aluOut[31:2] - DATA_BASE[31:2];
  assign ramIdx    = DIDX'(dataWord % 30'(DATA_MEMORY_DEPTH));
  assign isPortOut = (aluOut[31:2] == PORT_OUT_ADDR[31:2]);
  assign isPortIn  = (aluOut[31:2] == PORT_IN_ADDR[31:2]);

  mips_mc_control u_control (
    .clk         (clk),
    .reset       (reset),
    .irOpcode    (opcode),
    .irFunct     (funct),
    .fetchOpcode (fetchedInstr[31:26]),
    .fetchFunct  (fetchedInstr[5:0]),
    .state       (state),
    .instrClass  (instrClass),
    .aluOp       (aluOp),
    .instrDone   (InstrDone),
    .halted      (Halted)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= TEXT_BASE;
      ir         <= '0;
      regA       <= '0;
      regB       <= '0;
      aluOut     <= '0;
      mdr        <= '0;
      portOutReg <= '0;
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
      regFile[28] <= DATA_BASE;
      regFile[29] <= DATA_BASE + 32'(4 * DATA_MEMORY_DEPTH) - 32'd4;
    end else begin
      case (state)
        FETCH: begin
          ir <= fetchedInstr;
          pc <= pc + 32'd4;
        end
        DECODE: begin
          regA   <= regFile[rs];
          regB   <= regFile[rt];
          aluOut <= pc + (immSext << 2);
          if (instrClass == CLS_JUMP) begin
            // jr reads rs directly since A is only being latched on this same edge.
            if (opcode == OP_RTYPE) pc <= regFile[rs];
            else                    pc <= {pc[31:28], target, 2'b00};
            if (opcode == OP_JAL) regFile[31] <= pc;
          end
        end
        EXEC: begin
          if (instrClass == CLS_BRANCH) begin
            if (takenBranch) pc <= aluOut;
          end else begin
            aluOut <= aluResult;
          end
        end
        MEM: begin
          if (instrClass == CLS_LOAD)
            mdr <= isPortIn ? 32'(PortIn) : dataMem[ramIdx];
          else if (isPortOut)
            portOutReg <= regB;
        end
        WB: begin
          if (wbReg != 5'd0) regFile[wbReg] <= wbData;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset && state == MEM && instrClass == CLS_STORE && !isPortOut)
      dataMem[ramIdx] <= regB;
  end

  assign ALUResultOut = aluOut;
  assign PortOut      = portOutReg;

endmodule

// File: tb/tb_mips_multicycle_processor.sv
// tb/tb_mips_multicycle_processor.sv - directed program bench for mips_multicycle_processor
module tb_mips_multicycle_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  PortIn = 8'h00;
  logic [31:0] ALUResultOut, PortOut;
  logic        InstrDone, Halted;

  int nCompared = 0;
  int nMismatched = 0;

  mips_multicycle_processor #(
    .MEMORY_DEPTH(32), .DATA_MEMORY_DEPTH(64), .PORT_WIDTH(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PortIn       (PortIn),
    .ALUResultOut (ALUResultOut),
    .PortOut      (PortOut),
    .InstrDone    (InstrDone),
    .Halted       (Halted)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearProgram();
    for (int i = 0; i < 32; i++) dut.progMem[i] = 32'h0;
  endtask

  task automatic holdReset();
    reset = 1'b0;
    stepCycles(2);
  endtask

  logic [11:0] doneTrace;
  logic [31:0] aluAtCycle12;
  logic [31:0] swWord;

  initial begin
    // addi $t0,$0,5 ; addi $t1,$0,7 ; add $t2,$t0,$t1
    clearProgram();
    dut.progMem[0] = 32'h2008_0005;
    dut.progMem[1] = 32'h2009_0007;
    dut.progMem[2] = 32'h0109_5020;
    holdReset();
    checkValue("rst_pc", dut.pc, 32'h0040_0000);
    checkValue("rst_halted", {31'b0, Halted}, 32'd0);
    checkValue("rst_done", {31'b0, InstrDone}, 32'd0);
    checkValue("rst_portout", PortOut, 32'd0);
    checkValue("rst_aluout", ALUResultOut, 32'd0);
    checkValue("rst_sp", dut.regFile[29], 32'h1001_00FC);
    checkValue("rst_gp", dut.regFile[28], 32'h1001_0000);
    reset = 1'b1;
    aluAtCycle12 = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      doneTrace[c-1] = InstrDone;
      if (c == 12) aluAtCycle12 = ALUResultOut;
      stepCycles(1);
    end
    checkValue("add_done_trace", {20'b0, doneTrace}, 32'h0000_0888);
    checkValue("add_aluout", aluAtCycle12, 32'd12);
    checkValue("add_t0", dut.regFile[8], 32'd5);
    checkValue("add_t2", dut.regFile[10], 32'd12);

    // MMIO out/in, RAM store/load and RAM index wrap
    clearProgram();
    dut.progMem[0] = 32'h2008_0055;  // addi $t0,$0,0x55
    dut.progMem[1] = 32'hAF88_0024;  // sw   $t0,0x24($gp)
    dut.progMem[2] = 32'h8F89_0028;  // lw   $t1,0x28($gp)
    dut.progMem[3] = 32'hAF88_0004;  // sw   $t0,4($gp)
    dut.progMem[4] = 32'h8F8A_0004;  // lw   $t2,4($gp)
    dut.progMem[5] = 32'h8F8B_0104;  // lw   $t3,0x104($gp)
    dut.dataMem[9]  = 32'hDEAD_BEEF;
    dut.dataMem[10] = 32'h1234_5678;
    dut.dataMem[1]  = 32'h0;
    PortIn = 8'hA3;
    holdReset();
    reset = 1'b1;
    stepCycles(7);
    checkValue("sw_port_before", PortOut, 32'd0);
    stepCycles(1);
    checkValue("sw_port_cycle8", PortOut, 32'h55);
    checkValue("sw_port_ram_untouched", dut.dataMem[9], 32'hDEAD_BEEF);
    stepCycles(5);
    checkValue("lw_portin", dut.regFile[9], 32'h0000_00A3);
    stepCycles(14);
    checkValue("sw_ram", dut.dataMem[1], 32'h55);
    checkValue("lw_ram", dut.regFile[10], 32'h55);
    checkValue("lw_ram_wrap", dut.regFile[11], 32'h55);

    // beq taken
    clearProgram();
    dut.progMem[0] = 32'h1000_0002;  // beq $0,$0,+2
    dut.progMem[1] = 32'h2008_0009;
    dut.progMem[2] = 32'h2008_0009;
    dut.progMem[3] = 32'h2008_0001;  // addi $t0,$0,1
    holdReset();
    reset = 1'b1;
    stepCycles(2);
    checkValue("beq_done_cycle3", {31'b0, InstrDone}, 32'd1);
    stepCycles(1);
    checkValue("beq_pc", dut.pc, 32'h0040_000C);
    stepCycles(4);
    checkValue("beq_target_exec", dut.regFile[8], 32'd1);

    // bne not taken
    clearProgram();
    dut.progMem[0] = 32'h1400_0002;  // bne $0,$0,+2
    dut.progMem[1] = 32'h2008_0009;  // addi $t0,$0,9
    holdReset();
    reset = 1'b1;
    stepCycles(3);
    checkValue("bne_pc", dut.pc, 32'h0040_0004);
    stepCycles(4);
    checkValue("bne_fallthrough", dut.regFile[8], 32'd9);

    // jal / jr
    clearProgram();
    dut.progMem[0] = 32'h0C10_0004;  // jal 0x00400010
    dut.progMem[1] = 32'h2008_0003;  // addi $t0,$0,3
    dut.progMem[4] = 32'h03E0_0008;  // jr $31
    holdReset();
    reset = 1'b1;
    stepCycles(1);
    checkValue("jal_done_cycle2", {31'b0, InstrDone}, 32'd1);
    stepCycles(1);
    checkValue("jal_ra", dut.regFile[31], 32'h0040_0004);
    checkValue("jal_pc", dut.pc, 32'h0040_0010);
    stepCycles(2);
    checkValue("jr_pc", dut.pc, 32'h0040_0004);
    stepCycles(4);
    checkValue("jr_return_exec", dut.regFile[8], 32'd3);

    // Undefined funct traps at cycle 3
    clearProgram();
    dut.progMem[0] = 32'h0000_003F;
    holdReset();
    reset = 1'b1;
    stepCycles(1);
    checkValue("trap_funct_c2", {31'b0, Halted}, 32'd0);
    stepCycles(1);
    checkValue("trap_funct_c3", {31'b0, Halted}, 32'd1);

    // Undefined opcode after a port write: state must freeze
    clearProgram();
    dut.progMem[0] = 32'h2008_0055;  // addi $t0,$0,0x55
    dut.progMem[1] = 32'hAF88_0024;  // sw $t0,0x24($gp)
    dut.progMem[2] = 32'hFC00_0000;  // opcode 0x3F
    dut.progMem[3] = 32'hAF80_0024;  // sw $0,0x24($gp)
    dut.progMem[4] = 32'h2008_0007;  // addi $t0,$0,7
    holdReset();
    reset = 1'b1;
    stepCycles(9);
    checkValue("trap_op_before", {31'b0, Halted}, 32'd0);
    stepCycles(1);
    checkValue("trap_op_entered", {31'b0, Halted}, 32'd1);
    stepCycles(20);
    checkValue("trap_held", {31'b0, Halted}, 32'd1);
    checkValue("trap_portout_frozen", PortOut, 32'h55);
    checkValue("trap_reg_frozen", dut.regFile[8], 32'h55);
    checkValue("trap_pc_frozen", dut.pc, 32'h0040_000C);
    reset = 1'b0;
    stepCycles(1);
    checkValue("trap_reset_pc", dut.pc, 32'h0040_0000);
    checkValue("trap_reset_halted", {31'b0, Halted}, 32'd0);
    reset = 1'b1;

    // Reset during MEM of a store: RAM target, then port target
    for (int v = 0; v < 2; v++) begin
      swWord = (v == 0) ? 32'hAF88_0008 : 32'hAF88_0024;
      clearProgram();
      dut.progMem[0] = 32'h2008_0055;
      dut.progMem[1] = swWord;
      dut.dataMem[2] = 32'hCAFE_F00D;
      holdReset();
      reset = 1'b1;
      stepCycles(7);
      reset = 1'b0;
      stepCycles(1);
      checkValue(v == 0 ? "abort_ram" : "abort_port",
                 v == 0 ? dut.dataMem[2] : PortOut,
                 v == 0 ? 32'hCAFE_F00D : 32'h0);
      checkValue("abort_pc", dut.pc, 32'h0040_0000);
      checkValue("abort_reg", dut.regFile[8], 32'h0);
      reset = 1'b1;
      stepCycles(8);
      checkValue(v == 0 ? "restart_ram" : "restart_port",
                 v == 0 ? dut.dataMem[2] : PortOut, 32'h55);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
